paddle_draw: RTL and testbench

- Consumer of the paddle position bus (10-bit paddle centre X) produced by the paddle movement logic.
- Once per frame tick, compares the requested paddle X with the X currently on screen. If they differ, it erases the old paddle rectangle and then draws the new one.
- Drives the VGA adapter plot interface (x, y, colour, plot strobe), one pixel per clock.

---
 rtl/paddle_draw.sv | 173 +++++++++++++++++
 tb/tb_paddle_draw.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/paddle_draw.sv
// paddle_draw: erases the previously shown paddle and plots the new one
// through the VGA adapter pixel interface, one pixel per clock.
module paddle_draw #(
  parameter int          SCREEN_W  = 640,
  parameter int          HALF_W    = 40,
  parameter int          PADDLE_Y  = 460,
  parameter int          PADDLE_H  = 4,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] paddle_x,
  input  logic       frame_tick,
  output logic [9:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [10:0] HALF_W11 = 11'(HALF_W);
  localparam logic [10:0] X_MAX11  = 11'(SCREEN_W - 1);
  localparam logic [8:0]  Y_TOP    = 9'(PADDLE_Y);
  localparam logic [8:0]  Y_BOT    = 9'(PADDLE_Y + PADDLE_H - 1);

  typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, FINISH} state_t;

  state_t      state_q, state_d;
  logic [9:0]  new_x_q, new_x_d;
  logic [9:0]  shown_x_q, shown_x_d;
  logic        shown_valid_q, shown_valid_d;
  logic [10:0] old_left_q, old_left_d, old_right_q, old_right_d;
  logic        drew_q, drew_d;
  logic [9:0]  vga_x_q, vga_x_d;
  logic [8:0]  vga_y_q, vga_y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [10:0] nx11, nx_plus, new_left, new_right;

  // Clipped bounds of the latched centre; 11-bit so left never wraps below 0.
  always_comb begin
    nx11      = {1'b0, new_x_q};
    nx_plus   = nx11 + HALF_W11;
    new_left  = (nx11 >= HALF_W11) ? (nx11 - HALF_W11) : 11'd0;
    new_right = (nx_plus > X_MAX11) ? X_MAX11 : nx_plus;
  end

  // Next-state, sweep counters and registered output values.
  always_comb begin
    state_d       = state_q;
    new_x_d       = new_x_q;
    shown_x_d     = shown_x_q;
    shown_valid_d = shown_valid_q;
    old_left_d    = old_left_q;
    old_right_d   = old_right_q;
    drew_d        = drew_q;
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    colour_d      = colour_q;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          new_x_d = paddle_x;
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (shown_valid_q && (new_x_q == shown_x_q)) begin
          drew_d  = 1'b0;
          state_d = FINISH;
        end else begin
          drew_d = 1'b1;
          // An empty old rectangle (fully clipped) has nothing to erase.
          if (shown_valid_q && (old_left_q <= old_right_q)) begin
            state_d  = ERASE;
            vga_x_d  = old_left_q[9:0];
            vga_y_d  = Y_TOP;
            colour_d = BG_COLOUR;
          end else if (new_left <= new_right) begin
            state_d  = DRAW;
            vga_x_d  = new_left[9:0];
            vga_y_d  = Y_TOP;
            colour_d = FG_COLOUR;
          end else begin
            state_d = FINISH;
          end
        end
      end
      ERASE: begin
        if ({1'b0, vga_x_q} < old_right_q) begin
          vga_x_d = vga_x_q + 10'd1;
        end else if (vga_y_q < Y_BOT) begin
          vga_x_d = old_left_q[9:0];
          vga_y_d = vga_y_q + 9'd1;
        end else if (new_left <= new_right) begin
          state_d  = DRAW;
          vga_x_d  = new_left[9:0];
          vga_y_d  = Y_TOP;
          colour_d = FG_COLOUR;
        end else begin
          state_d = FINISH;
        end
      end
      DRAW: begin
        if ({1'b0, vga_x_q} < new_right) begin
          vga_x_d = vga_x_q + 10'd1;
        end else if (vga_y_q < Y_BOT) begin
          vga_x_d = new_left[9:0];
          vga_y_d = vga_y_q + 9'd1;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (drew_q) begin
          shown_x_d     = new_x_q;
          shown_valid_d = 1'b1;
          old_left_d    = new_left;
          old_right_d   = new_right;
        end
      end
      default: state_d = IDLE;
    endcase
    plot_d = (state_d == ERASE) || (state_d == DRAW);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      new_x_q       <= '0;
      shown_x_q     <= '0;
      shown_valid_q <= 1'b0;
      old_left_q    <= '0;
      old_right_q   <= '0;
      drew_q        <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      colour_q      <= BG_COLOUR;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      new_x_q       <= new_x_d;
      shown_x_q     <= shown_x_d;
      shown_valid_q <= shown_valid_d;
      old_left_q    <= old_left_d;
      old_right_q   <= old_right_d;
      drew_q        <= drew_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign vga_x  = vga_x_q;
  assign vga_y  = vga_y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_paddle_draw.sv
// Scoreboard bench for paddle_draw: expected pixels/done pulses are queued
// by the stimulus, a forked monitor pops and compares on every output.
module tb_paddle_draw;
  logic       clk = 1'b0;
  logic       reset, frame_tick;
  logic [9:0] paddle_x;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy, done;

  paddle_draw dut (
    .clk(clk), .reset(reset), .paddle_x(paddle_x), .frame_tick(frame_tick),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rect(input int l, input int r, input int c);
    exp_t e;
    for (int y = 460; y <= 463; y++)
      for (int x = l; x <= r; x++) begin
        e.is_done = 1'b0; e.x = x; e.y = y; e.c = c;
        sb.push_back(e);
      end
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.x = 0; e.y = 0; e.c = 0;
    sb.push_back(e);
  endtask

  // One update: tick at px, expect n_exp plot cycles, check latency/busy.
  task automatic do_update(input logic [9:0] px, input int n_exp, input bit noise,
                           input string tag);
    int k, plots, busys;
    bit got;
    @(negedge clk);
    paddle_x = px; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    k = 0; plots = 0; busys = 0; got = 1'b0;
    while (!got && k < 2000) begin
      busys += int'(busy);
      plots += int'(plot);
      if (done) got = 1'b1;
      else begin
        if (noise && k > 2 && k < n_exp - 4) begin
          frame_tick = (k % 5 == 0);
          paddle_x   = 10'(k * 7);
        end else begin
          frame_tick = 1'b0;
          paddle_x   = px;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    frame_tick = 1'b0; paddle_x = px;
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_latency"}, k, n_exp + 1);
    chk({tag, "_busy_cycles"}, busys, n_exp + 2);
    chk({tag, "_plot_cycles"}, plots, n_exp);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; frame_tick = 1'b0; paddle_x = 10'd0;

    // Monitor: compare every plot or done cycle against the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (!reset && (plot || done)) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", int'(plot) * 2 + int'(done), 0);
          end else begin
            e = sb.pop_front();
            chk("plot_done_exclusive", int'(plot && done), 0);
            chk("out_kind_done", int'(done), int'(e.is_done));
            if (plot && !e.is_done) begin
              chk("pix_x", int'(vga_x), e.x);
              chk("pix_y", int'(vga_y), e.y);
              chk("pix_colour", int'(colour), e.c);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_colour", int'(colour), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // First draw, no erase.
    push_rect(280, 360, 7); push_done();
    do_update(10'd320, 324, 1'b0, "draw320");
    // Same position: skipped.
    push_done();
    do_update(10'd320, 0, 1'b0, "skip320");
    // Move by one: contiguous erase + draw.
    push_rect(280, 360, 0); push_rect(281, 361, 7); push_done();
    do_update(10'd321, 648, 1'b0, "move321");
    push_rect(281, 361, 0); push_rect(280, 360, 7); push_done();
    do_update(10'd320, 648, 1'b0, "back320");
    // Left clip.
    push_rect(280, 360, 0); push_rect(0, 50, 7); push_done();
    do_update(10'd10, 528, 1'b0, "left10");
    // Right clip with tick/paddle_x noise during the update.
    push_rect(0, 50, 0); push_rect(560, 639, 7); push_done();
    do_update(10'd600, 524, 1'b1, "right600_noise");
    // Fully off-screen: erase only, zero draw pixels.
    push_rect(560, 639, 0); push_done();
    do_update(10'd1000, 320, 1'b0, "off1000");
    // shown_x was still updated to 1000.
    push_done();
    do_update(10'd1000, 0, 1'b0, "skip1000");
    // Old rectangle empty: draw only.
    push_rect(280, 360, 7); push_done();
    do_update(10'd320, 324, 1'b0, "from_off320");

    // Reset in the middle of ERASE.
    push_rect(280, 360, 0);
    @(negedge clk);
    paddle_x = 10'd321; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_erase_plot", int'(plot), 1);
    chk("mid_erase_colour", int'(colour), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_busy", int'(busy), 0);
    sb.delete();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    // shown_valid cleared: draw only.
    push_rect(160, 240, 7); push_done();
    do_update(10'd200, 324, 1'b0, "after_rst200");

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
